// File: rtl/sblk_conv_seq.sv
// rtl/sblk_conv_seq.sv - conv unit address sequencer with psum write-back delay line
module sblk_conv_seq #(
    parameter int WBUF_ADDR_W    = 10,
    parameter int ACTBUF_ADDRH_W = 6,
    parameter int PBUF_ADDR_W    = 9,
    parameter int PSUM_LAT       = 6
) (
    input  logic                      clk_l,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [7:0]                cfg_n_ci_m1,
    input  logic [3:0]                cfg_n_k_m1,
    input  logic [PBUF_ADDR_W-1:0]    cfg_n_pix_m1,
    input  logic [ACTBUF_ADDRH_W-1:0] cfg_act_base,
    input  logic [WBUF_ADDR_W-1:0]    cfg_w_base,
    output logic                      busy,
    output logic                      done,
    output logic                      first_pass,
    output logic [ACTBUF_ADDRH_W-1:0] actbuf_rd_addrh,
    output logic [WBUF_ADDR_W-1:0]    wbuf_rd_addr,
    output logic [PBUF_ADDR_W-1:0]    pbuf_rd_addr,
    output logic                      pbuf_wr_en,
    output logic [PBUF_ADDR_W-1:0]    pbuf_wr_addr
);

    // Pass counter must reach max(n_pix-1, PSUM_LAT), so size it for either bound.
    localparam int LAT_W = $clog2(PSUM_LAT + 1);
    localparam int PC_W  = (LAT_W > PBUF_ADDR_W) ? LAT_W : PBUF_ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;

    logic [7:0]                  r_n_ci_m1;
    logic [3:0]                  r_n_k_m1;
    logic [PBUF_ADDR_W-1:0]      r_n_pix_m1;
    logic [ACTBUF_ADDRH_W-1:0]   r_act_base;
    logic [PC_W-1:0]             r_pass_last;

    logic [7:0]                  r_ci;
    logic [3:0]                  r_k;
    logic [PC_W-1:0]             r_p;
    logic [WBUF_ADDR_W-1:0]      r_w_ptr;

    logic                        r_rd_valid;
    logic                        r_first;
    logic [ACTBUF_ADDRH_W-1:0]   r_act;
    logic [WBUF_ADDR_W-1:0]      r_w;
    logic [PBUF_ADDR_W-1:0]      r_prd;
    logic                        r_busy;

    logic                        r_dl_v [PSUM_LAT];
    logic [PBUF_ADDR_W-1:0]      r_dl_a [PSUM_LAT];

    logic [PC_W-1:0]             w_cfg_pass_last;
    logic                        w_beat_valid;
    logic                        w_pass_end;
    logic                        w_last;
    logic                        w_dl_busy;
    logic                        w_drain_done;
    logic [ACTBUF_ADDRH_W-1:0]   w_act_addr;

    assign w_cfg_pass_last = (PC_W'(cfg_n_pix_m1) > PC_W'(PSUM_LAT)) ? PC_W'(cfg_n_pix_m1)
                                                                     : PC_W'(PSUM_LAT);
    assign w_beat_valid    = (r_p <= PC_W'(r_n_pix_m1));
    assign w_pass_end      = (r_p == r_pass_last);
    assign w_last          = w_pass_end && (r_k == r_n_k_m1) && (r_ci == r_n_ci_m1);
    assign w_act_addr      = r_act_base + ACTBUF_ADDRH_W'(r_p) + ACTBUF_ADDRH_W'(r_k);
    assign w_drain_done    = !r_rd_valid && !w_dl_busy;

    // Any valid still upstream of the tail means a write will appear next cycle.
    always_comb begin
        w_dl_busy = 1'b0;
        for (int i = 0; i < PSUM_LAT - 1; i++) begin
            w_dl_busy = w_dl_busy | r_dl_v[i];
        end
    end

    // State register.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state: run the loop nest, then drain until the last write has left the line.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drain_done) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Config latch, loop counters and registered read-address beat.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            r_n_ci_m1   <= '0;
            r_n_k_m1    <= '0;
            r_n_pix_m1  <= '0;
            r_act_base  <= '0;
            r_pass_last <= '0;
            r_ci        <= '0;
            r_k         <= '0;
            r_p         <= '0;
            r_w_ptr     <= '0;
            r_rd_valid  <= 1'b0;
            r_first     <= 1'b0;
            r_act       <= '0;
            r_w         <= '0;
            r_prd       <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_busy <= (r_state == S_RUN) || ((r_state == S_DRAIN) && !w_drain_done);
            if (r_state == S_RUN) begin
                if (w_beat_valid) begin
                    r_rd_valid <= 1'b1;
                    r_first    <= (r_ci == '0) && (r_k == '0);
                    r_prd      <= PBUF_ADDR_W'(r_p);
                    r_act      <= w_act_addr;
                    r_w        <= r_w_ptr;
                end else begin
                    // RAW bubble: addresses hold, nothing enters the write line.
                    r_rd_valid <= 1'b0;
                    r_first    <= 1'b0;
                end
                if (w_pass_end) begin
                    r_p     <= '0;
                    r_w_ptr <= r_w_ptr + 1'b1;
                    if (r_k == r_n_k_m1) begin
                        r_k  <= '0;
                        r_ci <= r_ci + 1'b1;
                    end else begin
                        r_k  <= r_k + 1'b1;
                    end
                end else begin
                    r_p <= r_p + 1'b1;
                end
            end else begin
                r_rd_valid <= 1'b0;
                r_first    <= 1'b0;
                r_act      <= '0;
                r_w        <= '0;
                r_prd      <= '0;
                if ((r_state == S_IDLE) && start) begin
                    r_n_ci_m1   <= cfg_n_ci_m1;
                    r_n_k_m1    <= cfg_n_k_m1;
                    r_n_pix_m1  <= cfg_n_pix_m1;
                    r_act_base  <= cfg_act_base;
                    r_pass_last <= w_cfg_pass_last;
                    r_ci        <= '0;
                    r_k         <= '0;
                    r_p         <= '0;
                    r_w_ptr     <= cfg_w_base;
                end
            end
        end
    end

    // Write-back delay line: each read beat reappears as a write PSUM_LAT cycles later.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PSUM_LAT; i++) begin
                r_dl_v[i] <= 1'b0;
                r_dl_a[i] <= '0;
            end
        end else begin
            r_dl_v[0] <= r_rd_valid;
            r_dl_a[0] <= r_prd;
            for (int i = 1; i < PSUM_LAT; i++) begin
                r_dl_v[i] <= r_dl_v[i-1];
                r_dl_a[i] <= r_dl_a[i-1];
            end
        end
    end

    assign busy            = r_busy;
    assign done            = (r_state == S_DONE);
    assign first_pass      = r_first;
    assign actbuf_rd_addrh = r_act;
    assign wbuf_rd_addr    = r_w;
    assign pbuf_rd_addr    = r_prd;
    assign pbuf_wr_en      = r_dl_v[PSUM_LAT-1];
    assign pbuf_wr_addr    = r_dl_a[PSUM_LAT-1];

endmodule

// File: tb/tb_sblk_conv_seq.sv
// tb/tb_sblk_conv_seq.sv - self-checking bench for sblk_conv_seq
module tb_sblk_conv_seq;

    localparam int LAT  = 6;
    localparam int MAXC = 1024;

    logic       clk_l = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] cfg_n_ci_m1 = '0;
    logic [3:0] cfg_n_k_m1 = '0;
    logic [8:0] cfg_n_pix_m1 = '0;
    logic [5:0] cfg_act_base = '0;
    logic [9:0] cfg_w_base = '0;
    logic       busy, done, first_pass, pbuf_wr_en;
    logic [5:0] actbuf_rd_addrh;
    logic [9:0] wbuf_rd_addr;
    logic [8:0] pbuf_rd_addr, pbuf_wr_addr;

    sblk_conv_seq #(
        .WBUF_ADDR_W(10), .ACTBUF_ADDRH_W(6), .PBUF_ADDR_W(9), .PSUM_LAT(LAT)
    ) dut (
        .clk_l(clk_l), .rst_n(rst_n), .start(start),
        .cfg_n_ci_m1(cfg_n_ci_m1), .cfg_n_k_m1(cfg_n_k_m1), .cfg_n_pix_m1(cfg_n_pix_m1),
        .cfg_act_base(cfg_act_base), .cfg_w_base(cfg_w_base),
        .busy(busy), .done(done), .first_pass(first_pass),
        .actbuf_rd_addrh(actbuf_rd_addrh), .wbuf_rd_addr(wbuf_rd_addr),
        .pbuf_rd_addr(pbuf_rd_addr), .pbuf_wr_en(pbuf_wr_en), .pbuf_wr_addr(pbuf_wr_addr)
    );

    always #5 clk_l = ~clk_l;

    typedef struct {
        int ci_m1; int k_m1; int pix_m1; int act; int w;
        bit disturb; int exp_wr; int exp_done;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    int e_busy [MAXC]; int e_done [MAXC]; int e_fp [MAXC]; int e_act [MAXC];
    int e_w [MAXC];    int e_prd [MAXC];  int e_we [MAXC]; int e_wad [MAXC];
    int e_val [MAXC];
    int m_done_c;

    task automatic check(input string name, input int cyc, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // Reference: place every beat at its cycle by loop-nest arithmetic, then derive holds, writes, done.
    task automatic build_model(input vec_t v);
        int n_ci, n_k, n_pix, len, nb, c, last_wr;
        n_ci = v.ci_m1 + 1; n_k = v.k_m1 + 1; n_pix = v.pix_m1 + 1;
        len = (n_pix > LAT + 1) ? n_pix : LAT + 1;
        nb = n_ci * n_k * len;
        for (int i = 0; i < MAXC; i++) begin
            e_busy[i] = 0; e_done[i] = 0; e_fp[i] = 0; e_act[i] = 0; e_w[i] = 0;
            e_prd[i] = 0; e_we[i] = 0; e_wad[i] = 0; e_val[i] = 0;
        end
        last_wr = 0;
        for (int ci = 0; ci < n_ci; ci++)
            for (int k = 0; k < n_k; k++)
                for (int p = 0; p < n_pix; p++) begin
                    c = 1 + (ci * n_k + k) * len + p;
                    e_val[c] = 1;
                    e_prd[c] = p;
                    e_act[c] = (v.act + p + k) % 64;
                    e_w[c]   = (v.w + ci * n_k + k) % 1024;
                    e_fp[c]  = (ci == 0 && k == 0) ? 1 : 0;
                    e_we[c + LAT]  = 1;
                    e_wad[c + LAT] = p;
                    if (c + LAT > last_wr) last_wr = c + LAT;
                end
        for (int cc = 1; cc <= nb; cc++)
            if (e_val[cc] == 0) begin
                e_act[cc] = e_act[cc-1]; e_w[cc] = e_w[cc-1]; e_prd[cc] = e_prd[cc-1];
            end
        m_done_c = last_wr + 1;
        e_done[m_done_c] = 1;
        for (int cc = 1; cc < m_done_c; cc++) e_busy[cc] = 1;
    endtask

    function automatic logic [63:0] pack_exp(input int c);
        logic [63:0] r;
        r = {35'd0, e_busy[c][0], e_done[c][0], e_fp[c][0], e_act[c][5:0], e_w[c][9:0],
             e_prd[c][8:0], e_we[c][0]};
        return r;
    endfunction

    function automatic logic [63:0] pack_got();
        logic [63:0] r;
        r = {35'd0, busy, done, first_pass, actbuf_rd_addrh, wbuf_rd_addr, pbuf_rd_addr, pbuf_wr_en};
        return r;
    endfunction

    // One run; with disturb, start is pulsed in RUN and DRAIN and cfg is scrambled mid-run.
    // A non-negative rst_cyc pulls rst_n low in that cycle and ends the run there.
    task automatic run_cfg(input vec_t v, input int rst_cyc, output int n_wr, output int n_done,
                           output int done_at);
        build_model(v);
        n_wr = 0; n_done = 0; done_at = -1;
        @(posedge clk_l); #1;
        cfg_n_ci_m1 = 8'(v.ci_m1); cfg_n_k_m1 = 4'(v.k_m1); cfg_n_pix_m1 = 9'(v.pix_m1);
        cfg_act_base = 6'(v.act); cfg_w_base = 10'(v.w);
        start = 1'b1;
        @(posedge clk_l); #1;
        start = 1'b0;
        for (int cyc = 0; cyc <= m_done_c + 3; cyc++) begin
            if (cyc == rst_cyc) begin
                rst_n = 1'b0;
                @(negedge clk_l);
                check("reset_outputs_zero", cyc, pack_got(), 64'd0);
                check("reset_wr_addr_zero", cyc, 64'(pbuf_wr_addr), 64'd0);
                return;
            end
            if (v.disturb && (cyc == 5 || cyc == m_done_c - 2)) begin
                start = 1'b1;
                cfg_n_ci_m1 = 8'($urandom); cfg_n_k_m1 = 4'($urandom); cfg_n_pix_m1 = 9'($urandom);
                cfg_act_base = 6'($urandom); cfg_w_base = 10'($urandom);
            end
            @(negedge clk_l);
            check("beat", cyc, pack_got(), pack_exp(cyc));
            if (e_we[cyc] != 0) check("wr_addr", cyc, 64'(pbuf_wr_addr), 64'(e_wad[cyc]));
            if (pbuf_wr_en) n_wr++;
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = cyc;
            end
            @(posedge clk_l); #1;
            start = 1'b0;
        end
    endtask

    vec_t tbl [4];
    vec_t rv;
    int nw, nd, da;

    initial begin
        tbl[0] = '{ci_m1:0, k_m1:0, pix_m1:15, act:0,  w:0,   disturb:0, exp_wr:16, exp_done:23};
        tbl[1] = '{ci_m1:1, k_m1:2, pix_m1:7,  act:4,  w:100, disturb:1, exp_wr:48, exp_done:55};
        tbl[2] = '{ci_m1:0, k_m1:1, pix_m1:2,  act:0,  w:0,   disturb:0, exp_wr:6,  exp_done:17};
        tbl[3] = '{ci_m1:0, k_m1:0, pix_m1:3,  act:62, w:0,   disturb:0, exp_wr:4,  exp_done:11};

        rst_n = 1'b0;
        repeat (2) @(posedge clk_l);
        @(negedge clk_l);
        check("por_outputs", 0, pack_got(), 64'd0);
        check("por_wr_addr", 0, 64'(pbuf_wr_addr), 64'd0);
        @(posedge clk_l); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_cfg(tbl[i], -1, nw, nd, da);
            check("tbl_write_count", i, 64'(nw), 64'(tbl[i].exp_wr));
            check("tbl_done_cycle", i, 64'(da), 64'(tbl[i].exp_done));
            check("tbl_done_count", i, 64'(nd), 64'd1);
        end

        for (int i = 0; i < 8; i++) begin
            rv = '{ci_m1:$urandom_range(0, 2), k_m1:$urandom_range(0, 3),
                   pix_m1:$urandom_range(0, 20), act:$urandom_range(0, 63),
                   w:$urandom_range(0, 1023), disturb:(i % 2 == 1), exp_wr:0, exp_done:0};
            run_cfg(rv, -1, nw, nd, da);
            check("rnd_write_count", i, 64'(nw), 64'((rv.ci_m1 + 1) * (rv.k_m1 + 1) * (rv.pix_m1 + 1)));
            check("rnd_done_count", i, 64'(nd), 64'd1);
        end

        // Reset at beat 10 of the 48-beat run: nothing may be written afterwards.
        run_cfg(tbl[1], 10, nw, nd, da);
        repeat (2) @(posedge clk_l);
        #1 rst_n = 1'b1;
        nw = 0; nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_l);
            if (pbuf_wr_en) nw++;
            if (busy || done) nd++;
        end
        check("post_reset_writes", 0, 64'(nw), 64'd0);
        check("post_reset_busy", 0, 64'(nd), 64'd0);
        run_cfg(tbl[1], -1, nw, nd, da);
        check("fresh_write_count", 0, 64'(nw), 64'd48);
        check("fresh_done_cycle", 0, 64'(da), 64'd55);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sblk_conv_seq.md
# sblk_conv_seq

Address sequencer for one SuperBlock conv unit, sitting directly upstream of it on clk_l. On a start pulse it walks the convolution loop nest (input-channel tile, kernel tap, output pixel) and drives one beat per cycle: weight-buffer read address, activation-buffer read half-address, and partial-sum buffer read address. It then replays the psum read address as the write-back address after the unit's fixed accumulate latency. The per-TPE skew delays stay inside the unit; this block emits undelayed addresses only.

## Interface
- WBUF_ADDR_W, 10, weight buffer address width
- ACTBUF_ADDRH_W, 6, activation buffer half-address width
- PBUF_ADDR_W, 9, psum buffer address width
- PSUM_LAT, 6, clk_l cycles from pbuf_rd_addr issue to matching pbuf write (>=1)
- clk_l  in  1  low-speed clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- cfg_n_ci_m1  in  8  input-channel tiles minus 1
- cfg_n_k_m1  in  4  kernel taps minus 1
- cfg_n_pix_m1  in  PBUF_ADDR_W  output pixels minus 1
- cfg_act_base  in  ACTBUF_ADDRH_W  activation start half-address
- cfg_w_base  in  WBUF_ADDR_W  weight start address
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle completion pulse
- first_pass  out  1  current beat belongs to ci=0, k=0 (psum-in must be treated as zero)
- actbuf_rd_addrh  out  ACTBUF_ADDRH_W  activation read half-address
- wbuf_rd_addr  out  WBUF_ADDR_W  weight read address
- pbuf_rd_addr  out  PBUF_ADDR_W  psum read address
- pbuf_wr_en  out  1  psum write enable
- pbuf_wr_addr  out  PBUF_ADDR_W  psum write address

## Operation
- Reset: state IDLE; all outputs 0; all counters and delay lines 0.
- States IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 latches all cfg_* and enters RUN; ci=k=p=0, w_ptr=cfg_w_base. Outputs held 0.
- RUN: loop order ci outer, k middle, p inner. Valid beat drives pbuf_rd_addr=p, actbuf_rd_addrh=(cfg_act_base+p+k) mod 2^ACTBUF_ADDRH_W, wbuf_rd_addr=w_ptr (mod 2^WBUF_ADDR_W), first_pass=(ci==0 && k==0).
- Pass = one full p sweep. After each pass, k increments and w_ptr increments by 1. When k wraps, k=0 and ci increments. Net effect: w_ptr=cfg_w_base+ci*(n_k)+k.
- RAW guard: each pass occupies max(n_pix, PSUM_LAT+1) cycles. When n_pix<=PSUM_LAT, bubble cycles follow the last pixel. During bubbles, addresses hold, first_pass=0, and no valid enters the write delay line.
- Write-back: a PSUM_LAT-deep shift line carries {valid, p}. pbuf_wr_en and pbuf_wr_addr are the line tail.
- After the last beat (ci, k, p all at max), go to DRAIN. Addresses and first_pass return to 0.
- DRAIN: wait until the delay line holds no valid, then go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- start outside IDLE is ignored; cfg changes after latch have no effect.
- rst_n asserted mid-operation: immediate return to reset state, delay line flushed, no further writes.

## Timing
- Start accepted at edge 0. busy=1 and the first beat are visible after edge 1.
- Beat count B = (n_ci)(n_k)*max(n_pix, PSUM_LAT+1) cycles; the last beat is in cycle B.
- Each beat's write appears exactly PSUM_LAT cycles after its read-address cycle.
- done asserts the cycle after the last pbuf_wr_en cycle. busy falls in that same cycle.
- A new start is accepted in the cycle after done.

## Test plan
- Basic (n_ci=1, n_k=1, n_pix=16, PSUM_LAT=6, bases 0) -> pbuf_rd_addr 0..15 in cycles 1..16, first_pass high throughout; pbuf_wr_en cycles 7..22 with addr 0..15; done at cycle 23.
- Loop nest (n_ci=2, n_k=3, n_pix=8, act_base=4, w_base=100) -> 48 beats. wbuf_rd_addr steps 100..105, one per pass. actbuf_rd_addrh = 4+p+k. first_pass only in the first 8 beats.
- RAW guard (n_pix=3, PSUM_LAT=6, n_k=2) -> each pass is 7 cycles: 3 beats + 4 bubbles. Each pixel's write precedes its next read. Exactly 6 writes.
- Wrap (act_base=62, n_pix=4, ACTBUF_ADDRH_W=6) -> actbuf_rd_addrh sequence 62, 63, 0, 1.
- start pulsed during RUN and DRAIN -> ignored; exactly one done; cfg change mid-run does not affect addresses.
- rst_n low at beat 10 of a 48-beat run -> all outputs 0 next cycle; no pbuf_wr_en after release; a fresh start then runs the full sequence.
